store_buffer_request_unit: RTL and testbench
============================================

Name: store_buffer_request_unit

Overview:
- Parametrised successor to the single-outstanding data request path between the pipeline MEM stage and the data cache.
- Adds a DEPTH-entry FIFO store buffer, so stores retire without waiting on the cache.
- Loads are forwarded from the youngest matching buffered store. Unmatched loads go to the cache with priority over buffer drain.
- Supports a halt-drain mode so all buffered stores commit before the core signals halt.

Parameters:
ADDR_W, 32, address width in bits; bits [1:0] are ignored for matching (word-aligned)
DATA_W, 32, load/store data width
SB_DEPTH, 4, store buffer entries; power of two, at least 2

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
dmemREN  in  1  MEM-stage load request
dmemWEN  in  1  MEM-stage store request
dmemaddr  in  ADDR_W  request address
dmemstore  in  DATA_W  store data
halt  in  1  core halt; stop accepting requests and drain
dmemload  out  DATA_W  load result, valid while dhit=1 for a load
dhit  out  1  request complete; datapath advances MEM stage
drained  out  1  halt=1, buffer empty, FSM in IDLE
sb_count  out  $clog2(SB_DEPTH)+1  current buffer occupancy
c_ren  out  1  cache read request
c_wen  out  1  cache write request
c_addr  out  ADDR_W  cache address
c_store  out  DATA_W  cache write data
c_load  in  DATA_W  cache read data
c_hit  in  1  cache completes the current c_ren/c_wen this cycle

Behaviour:
- Reset: FSM=IDLE; head, tail and count=0; all entries invalid. dhit, c_ren, c_wen, drained=0; c_addr, c_store, dmemload=0.
- Reset mid-transaction: buffered stores are discarded. c_ren/c_wen are low from the cycle after RST is sampled.
- Request legality: dmemREN and dmemWEN together is illegal; the unit treats it as a load and ignores the store.
- Store accept (dmemWEN=1, dmemREN=0, halt=0, count<SB_DEPTH):
  - dhit=1 combinationally that cycle.
  - Entry {addr, data} written at tail on the edge; tail wraps modulo SB_DEPTH.
- Store when full or halt=1: dhit=0; the datapath holds the request.
- Load forward (dmemREN=1, halt=0):
  - Compare dmemaddr[ADDR_W-1:2] against all valid entries.
  - On any match: dhit=1 and dmemload = data of the youngest match (closest to tail), same cycle. No cache access.
  - Forwarding works when the buffer is full and while the matching entry is the head being drained.
- FSM states:
  - IDLE: c_ren=c_wen=0. Unmatched load pending (dmemREN, halt=0, no match) -> LOAD. Otherwise, if count>0 -> DRAIN. Loads have priority.
  - LOAD: c_ren=1, c_addr=dmemaddr. On c_hit: dhit=1, dmemload=c_load, go to IDLE. Minimum load-miss latency is 1 cycle plus the cache latency.
  - DRAIN: c_wen=1, c_addr/c_store = head entry. On c_hit: pop head (head wraps), go to IDLE. A load arriving mid-drain waits for c_hit.
- Cache request stability: the cache request is held stable until c_hit. A started drain or load is never aborted except by RST.
- Store accepted in the same cycle as a pop: count unchanged, both pointers advance.
- Count range: count never exceeds SB_DEPTH or underflows.
- Halt:
  - halt=1 blocks new store accepts and load service (dhit=0).
  - An in-flight LOAD still completes and asserts dhit.
  - DRAIN continues until count=0.
  - drained is combinational: halt & count==0 & state==IDLE.
- Unused outputs: c_addr and c_store are 0 in IDLE. dmemload holds 0 when dhit=0.

Test Plan:
- Fill buffer, SB_DEPTH=4, cache stalled (c_hit=0):
  - 4 stores to 0x100..0x10C each get a same-cycle dhit; sb_count=4.
  - A 5th store to 0x110 sees dhit=0 until the first c_hit pops 0x100.
  - The 0x110 store is then accepted and sb_count returns to 4.
- Forward youngest: store 0x200<-0xAAAA then 0x200<-0xBBBB with the cache stalled. A load of 0x200 gets dhit same cycle with dmemload=0xBBBB, and c_ren stays 0.
- Load priority: buffer holds 2 stores, FSM in IDLE, unmatched load of 0x300 arrives.
  - Next cycle c_ren=1, c_addr=0x300. On c_hit with c_load=0x1234: dhit=1, dmemload=0x1234.
  - Drain then resumes: c_wen=1, c_addr = oldest store.
- Load during drain: a load arrives while DRAIN waits on c_hit. The load waits until c_hit, the FSM returns to IDLE, and LOAD is entered the following cycle.
- Halt drain: 3 stores buffered, halt=1.
  - A new store gets dhit=0.
  - Exactly 3 c_wen/c_hit handshakes occur in FIFO order.
  - drained=1 in the cycle after the last pop.
- Reset mid-operation: RST during DRAIN with count=3. Next cycle: sb_count=0, c_wen=0, FSM=IDLE. A subsequent load of a previously buffered address goes to the cache, not forwarded.

Source files
------------

// File: rtl/store_buffer_request_unit_if.sv
// Request/response bundle between the MEM stage, the store buffer unit and the data cache.
// The slave modport is the store buffer unit; the master modport is its environment
// (the datapath driving requests plus the cache answering them).
interface store_buffer_request_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  // MEM-stage side
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic [DATA_W-1:0] dmemload;
  logic              dhit;

  // Cache side
  logic              c_ren;
  logic              c_wen;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_store;
  logic [DATA_W-1:0] c_load;
  logic              c_hit;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, c_load, c_hit,
    output dmemload, dhit, c_ren, c_wen, c_addr, c_store
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, c_load, c_hit,
    input  dmemload, dhit, c_ren, c_wen, c_addr, c_store
  );

endinterface

// File: rtl/store_buffer_request_unit.sv
// Data request unit with a FIFO store buffer between the MEM stage and the data cache.
// Stores retire into the buffer, loads forward from the youngest matching entry, unmatched
// loads go to the cache ahead of buffer drain, and halt drains the buffer before signalling.
module store_buffer_request_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      halt,
  output logic                      drained,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  store_buffer_request_unit_if.slave bus
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [ADDR_W-1:0] addr_d [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [DATA_W-1:0] data_d [SB_DEPTH];

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PtrW-1:0]   fwd_idx;
  logic              load_req;
  logic              store_req;
  logic              push;
  logic              pop;

  logic              dhit;
  logic [DATA_W-1:0] dmemload;
  logic              c_ren;
  logic              c_wen;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_store;

  // Forwarding search: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) &&
          (addr_q[fwd_idx][ADDR_W-1:2] == bus.dmemaddr[ADDR_W-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Next-state, buffer update and all request/response outputs.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    dhit     = 1'b0;
    dmemload = '0;
    c_ren    = 1'b0;
    c_wen    = 1'b0;
    c_addr   = '0;
    c_store  = '0;
    push     = 1'b0;
    pop      = 1'b0;

    // A simultaneous load+store is treated as a load only.
    load_req  = bus.dmemREN & ~halt;
    store_req = bus.dmemWEN & ~bus.dmemREN & ~halt;

    unique case (state_q)
      StIdle: begin
        if (load_req && !fwd_hit) begin
          state_d = StLoad;
        end else if (count_q != '0) begin
          state_d = StDrain;
        end
      end
      StLoad: begin
        // In-flight load completes even if halt rose meanwhile.
        c_ren  = 1'b1;
        c_addr = bus.dmemaddr;
        if (bus.c_hit) begin
          dhit     = 1'b1;
          dmemload = bus.c_load;
          state_d  = StIdle;
        end
      end
      StDrain: begin
        c_wen   = 1'b1;
        c_addr  = addr_q[head_q];
        c_store = data_q[head_q];
        if (bus.c_hit) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Forwarded loads and store accepts complete in the same cycle outside a cache load.
    if (state_q != StLoad) begin
      if (load_req && fwd_hit) begin
        dhit     = 1'b1;
        dmemload = fwd_data;
      end else if (store_req && (count_q < CntW'(SB_DEPTH))) begin
        dhit = 1'b1;
        push = 1'b1;
      end
    end

    if (push) begin
      addr_d[tail_q] = bus.dmemaddr;
      data_d[tail_q] = bus.dmemstore;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // State, pointers and buffer storage; reset discards all buffered stores.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.dhit     = dhit;
  assign bus.dmemload = dmemload;
  assign bus.c_ren    = c_ren;
  assign bus.c_wen    = c_wen;
  assign bus.c_addr   = c_addr;
  assign bus.c_store  = c_store;
  assign sb_count     = count_q;
  assign drained      = halt & (count_q == '0) & (state_q == StIdle);

endmodule

// File: tb/tb_store_buffer_request_unit.sv
// Self-checking bench for store_buffer_request_unit: scenario tasks with inline checks plus a
// scoreboard of expected cache writes, filled on store accept and drained by a write monitor.
module tb_store_buffer_request_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       halt = 1'b0;
  logic       drained;
  logic [2:0] sb_count;

  int errors = 0;
  int checks = 0;
  int wr_hs  = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  store_buffer_request_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_buffer_request_unit #(.ADDR_W(32), .DATA_W(32), .SB_DEPTH(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .halt     (halt),
    .drained  (drained),
    .sb_count (sb_count),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  // Write monitor: every completed cache write must match the oldest expected store.
  always @(negedge CLK) begin
    if (!RST && bus.c_wen && bus.c_hit) begin
      wr_t e;
      wr_hs++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_order: got unexpected write addr=%h data=%h", bus.c_addr,
                 bus.c_store);
      end else begin
        e = exp_q.pop_front();
        if (bus.c_addr !== e.a || bus.c_store !== e.d) begin
          errors++;
          $display("FAIL drain_order: got addr=%h data=%h expected addr=%h data=%h",
                   bus.c_addr, bus.c_store, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d);
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b1;
    bus.dmemaddr  = a;
    bus.dmemstore = d;
  endtask

  task automatic set_load(input logic [31:0] a);
    bus.dmemREN   = 1'b1;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = a;
    bus.dmemstore = '0;
  endtask

  // Store expected to be accepted this cycle: check dhit and record the future cache write.
  task automatic store_ok(input string nm, input logic [31:0] a, input logic [31:0] d);
    cycle();
    set_store(a, d);
    #2;
    checks++;
    if (bus.dhit !== 1'b1) begin
      errors++;
      $display("FAIL %s: dhit=%b expected 1", nm, bus.dhit);
    end
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic drain_all(input string nm);
    cycle();
    drive_idle();
    bus.c_hit = 1'b1;
    #2;
    for (int i = 0; i < 100; i++) begin
      if (sb_count == 3'd0 && bus.c_wen == 1'b0) break;
      cycle();
      #2;
    end
    bus.c_hit = 1'b0;
    checks++;
    if (sb_count !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_empty: sb_count=%0d pending=%0d expected 0 and 0", nm, sb_count,
               exp_q.size());
    end
  endtask

  task automatic test_reset();
    drive_idle();
    bus.c_hit  = 1'b0;
    bus.c_load = '0;
    RST = 1'b1;
    cycle();
    cycle();
    #2;
    checks++;
    if (sb_count !== 3'd0 || bus.c_ren !== 1'b0 || bus.c_wen !== 1'b0 || bus.dhit !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: count=%0d ren=%b wen=%b dhit=%b expected 0 0 0 0", sb_count,
               bus.c_ren, bus.c_wen, bus.dhit);
    end
    checks++;
    if (drained !== 1'b0 || bus.c_addr !== 32'h0 || bus.c_store !== 32'h0 ||
        bus.dmemload !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: drained=%b c_addr=%h c_store=%h dmemload=%h expected all 0",
               drained, bus.c_addr, bus.c_store, bus.dmemload);
    end
    RST = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      store_ok("fill_dhit", 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
    end
    cycle();
    set_load(32'h108);
    #2;
    checks++;
    if (bus.dhit !== 1'b1 || bus.dmemload !== 32'h1002 || sb_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_fwd_full: dhit=%b load=%h count=%0d expected 1 00001002 4", bus.dhit,
               bus.dmemload, sb_count);
    end
    cycle();
    set_store(32'h110, 32'h1004);
    #2;
    checks++;
    if (bus.dhit !== 1'b0 || bus.c_wen !== 1'b1 || bus.c_addr !== 32'h100) begin
      errors++;
      $display("FAIL fill_full_stall: dhit=%b wen=%b c_addr=%h expected 0 1 00000100", bus.dhit,
               bus.c_wen, bus.c_addr);
    end
    cycle();
    cycle();
    bus.c_hit = 1'b1;
    #2;
    checks++;
    if (bus.dhit !== 1'b0) begin
      errors++;
      $display("FAIL fill_pop_cycle: dhit=%b expected 0", bus.dhit);
    end
    cycle();
    bus.c_hit = 1'b0;
    #2;
    checks++;
    if (bus.dhit !== 1'b1 || sb_count !== 3'd3) begin
      errors++;
      $display("FAIL fill_accept_after_pop: dhit=%b count=%0d expected 1 3", bus.dhit, sb_count);
    end
    exp_q.push_back('{a: 32'h110, d: 32'h1004});
    cycle();
    drive_idle();
    #2;
    checks++;
    if (sb_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_count_back: count=%0d expected 4", sb_count);
    end
    drain_all("fill");
  endtask

  task automatic test_forward_youngest();
    store_ok("fwd_st0", 32'h200, 32'hAAAA);
    store_ok("fwd_st1", 32'h200, 32'hBBBB);
    cycle();
    set_load(32'h200);
    #2;
    checks++;
    if (bus.dhit !== 1'b1 || bus.dmemload !== 32'hBBBB || bus.c_ren !== 1'b0) begin
      errors++;
      $display("FAIL fwd_youngest: dhit=%b load=%h ren=%b expected 1 0000bbbb 0", bus.dhit,
               bus.dmemload, bus.c_ren);
    end
    drain_all("fwd");
  endtask

  task automatic test_load_priority();
    store_ok("pri_st0", 32'h310, 32'h31);
    store_ok("pri_st1", 32'h314, 32'h32);
    store_ok("pri_st2", 32'h318, 32'h33);
    cycle();
    drive_idle();
    bus.c_hit = 1'b1;
    #2;
    checks++;
    if (bus.c_wen !== 1'b1 || bus.c_addr !== 32'h310) begin
      errors++;
      $display("FAIL pri_first_drain: wen=%b c_addr=%h expected 1 00000310", bus.c_wen,
               bus.c_addr);
    end
    cycle();
    bus.c_hit = 1'b0;
    set_load(32'h300);
    #2;
    checks++;
    if (bus.dhit !== 1'b0 || bus.c_ren !== 1'b0 || bus.c_wen !== 1'b0) begin
      errors++;
      $display("FAIL pri_idle: dhit=%b ren=%b wen=%b expected 0 0 0", bus.dhit, bus.c_ren,
               bus.c_wen);
    end
    cycle();
    #2;
    checks++;
    if (bus.c_ren !== 1'b1 || bus.c_addr !== 32'h300 || bus.c_wen !== 1'b0) begin
      errors++;
      $display("FAIL pri_load_req: ren=%b c_addr=%h wen=%b expected 1 00000300 0", bus.c_ren,
               bus.c_addr, bus.c_wen);
    end
    bus.c_hit  = 1'b1;
    bus.c_load = 32'h1234;
    #1;
    checks++;
    if (bus.dhit !== 1'b1 || bus.dmemload !== 32'h1234) begin
      errors++;
      $display("FAIL pri_load_data: dhit=%b load=%h expected 1 00001234", bus.dhit,
               bus.dmemload);
    end
    cycle();
    drive_idle();
    bus.c_hit = 1'b0;
    cycle();
    #2;
    checks++;
    if (bus.c_wen !== 1'b1 || bus.c_addr !== 32'h314) begin
      errors++;
      $display("FAIL pri_drain_resume: wen=%b c_addr=%h expected 1 00000314", bus.c_wen,
               bus.c_addr);
    end
    drain_all("pri");
  endtask

  task automatic test_load_during_drain();
    store_ok("ldd_st", 32'h400, 32'h4444);
    cycle();
    drive_idle();
    cycle();
    set_load(32'h500);
    #2;
    checks++;
    if (bus.c_wen !== 1'b1 || bus.dhit !== 1'b0 || bus.c_ren !== 1'b0) begin
      errors++;
      $display("FAIL ldd_wait: wen=%b dhit=%b ren=%b expected 1 0 0", bus.c_wen, bus.dhit,
               bus.c_ren);
    end
    cycle();
    bus.c_hit = 1'b1;
    #2;
    checks++;
    if (bus.dhit !== 1'b0) begin
      errors++;
      $display("FAIL ldd_drain_hit: dhit=%b expected 0", bus.dhit);
    end
    cycle();
    bus.c_hit = 1'b0;
    #2;
    checks++;
    if (bus.c_ren !== 1'b0 || sb_count !== 3'd0) begin
      errors++;
      $display("FAIL ldd_idle: ren=%b count=%0d expected 0 0", bus.c_ren, sb_count);
    end
    cycle();
    #2;
    checks++;
    if (bus.c_ren !== 1'b1 || bus.c_addr !== 32'h500) begin
      errors++;
      $display("FAIL ldd_load_req: ren=%b c_addr=%h expected 1 00000500", bus.c_ren,
               bus.c_addr);
    end
    bus.c_hit  = 1'b1;
    bus.c_load = 32'h5555;
    #1;
    checks++;
    if (bus.dhit !== 1'b1 || bus.dmemload !== 32'h5555) begin
      errors++;
      $display("FAIL ldd_load_data: dhit=%b load=%h expected 1 00005555", bus.dhit,
               bus.dmemload);
    end
    cycle();
    drive_idle();
    bus.c_hit = 1'b0;
  endtask

  task automatic test_halt_drain();
    int  base;
    bit  found;
    logic pp;
    store_ok("halt_st0", 32'h600, 32'h60);
    store_ok("halt_st1", 32'h604, 32'h61);
    store_ok("halt_st2", 32'h608, 32'h62);
    cycle();
    halt = 1'b1;
    set_store(32'h60C, 32'h63);
    #2;
    checks++;
    if (bus.dhit !== 1'b0 || drained !== 1'b0) begin
      errors++;
      $display("FAIL halt_block: dhit=%b drained=%b expected 0 0", bus.dhit, drained);
    end
    base  = wr_hs;
    found = 1'b0;
    pp    = 1'b0;
    bus.c_hit = 1'b1;
    #1;
    for (int i = 0; i < 50; i++) begin
      pp = bus.c_wen & bus.c_hit;
      cycle();
      #2;
      if (drained === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || pp !== 1'b1) begin
      errors++;
      $display("FAIL halt_drained: seen=%b after_pop=%b expected 1 1", found, pp);
    end
    checks++;
    if (wr_hs - base != 3 || sb_count !== 3'd0 || bus.dhit !== 1'b0) begin
      errors++;
      $display("FAIL halt_writes: writes=%0d count=%0d dhit=%b expected 3 0 0", wr_hs - base,
               sb_count, bus.dhit);
    end
    bus.c_hit = 1'b0;
    halt = 1'b0;
    #1;
    checks++;
    if (bus.dhit !== 1'b1) begin
      errors++;
      $display("FAIL halt_release: dhit=%b expected 1", bus.dhit);
    end
    exp_q.push_back('{a: 32'h60C, d: 32'h63});
    drain_all("halt");
  endtask

  task automatic test_reset_mid();
    store_ok("rst_st0", 32'h700, 32'h70);
    store_ok("rst_st1", 32'h704, 32'h71);
    store_ok("rst_st2", 32'h708, 32'h72);
    cycle();
    drive_idle();
    #2;
    checks++;
    if (bus.c_wen !== 1'b1 || sb_count !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre: wen=%b count=%0d expected 1 3", bus.c_wen, sb_count);
    end
    RST = 1'b1;
    exp_q.delete();
    cycle();
    RST = 1'b0;
    #2;
    checks++;
    if (sb_count !== 3'd0 || bus.c_wen !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: count=%0d wen=%b expected 0 0", sb_count, bus.c_wen);
    end
    set_load(32'h700);
    #1;
    checks++;
    if (bus.dhit !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_fwd: dhit=%b expected 0", bus.dhit);
    end
    cycle();
    #2;
    checks++;
    if (bus.c_ren !== 1'b1 || bus.c_addr !== 32'h700) begin
      errors++;
      $display("FAIL rst_load_req: ren=%b c_addr=%h expected 1 00000700", bus.c_ren,
               bus.c_addr);
    end
    bus.c_hit  = 1'b1;
    bus.c_load = 32'hCAFE;
    #1;
    checks++;
    if (bus.dhit !== 1'b1 || bus.dmemload !== 32'hCAFE) begin
      errors++;
      $display("FAIL rst_load_data: dhit=%b load=%h expected 1 0000cafe", bus.dhit,
               bus.dmemload);
    end
    cycle();
    drive_idle();
    bus.c_hit = 1'b0;
  endtask

  task automatic test_load_and_store();
    cycle();
    bus.dmemREN   = 1'b1;
    bus.dmemWEN   = 1'b1;
    bus.dmemaddr  = 32'h800;
    bus.dmemstore = 32'hDEAD;
    #2;
    checks++;
    if (bus.dhit !== 1'b0) begin
      errors++;
      $display("FAIL both_first: dhit=%b expected 0", bus.dhit);
    end
    cycle();
    #2;
    checks++;
    if (bus.c_ren !== 1'b1 || sb_count !== 3'd0) begin
      errors++;
      $display("FAIL both_as_load: ren=%b count=%0d expected 1 0", bus.c_ren, sb_count);
    end
    bus.c_hit  = 1'b1;
    bus.c_load = 32'h8888;
    #1;
    checks++;
    if (bus.dhit !== 1'b1 || bus.dmemload !== 32'h8888) begin
      errors++;
      $display("FAIL both_load_data: dhit=%b load=%h expected 1 00008888", bus.dhit,
               bus.dmemload);
    end
    cycle();
    drive_idle();
    bus.c_hit = 1'b0;
    #2;
    checks++;
    if (sb_count !== 3'd0 || bus.c_wen !== 1'b0) begin
      errors++;
      $display("FAIL both_store_ignored: count=%0d wen=%b expected 0 0", sb_count, bus.c_wen);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_forward_youngest();
    test_load_priority();
    test_load_during_drain();
    test_halt_drain();
    test_reset_mid();
    test_load_and_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
